// File: rtl/rv32i_pkg.sv
// Types and constants shared by the RV32I pipeline stages.
package rv32i_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

   // IF/ID pipeline entry; decode consumes the same layout.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
      logic        misaligned;
      logic        fault;
   } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, combinational imem address, IF/ID register
// with valid/ready handshake toward decode and redirect input from execute.
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter int          IMEM_DEPTH = 8192,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   localparam int         AW         = $clog2(IMEM_DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [AW-1:0] imem_addr_o,
   input  logic [31:0]   imem_data_i,
   input  logic          redirect_valid_i,
   input  logic [31:0]   redirect_pc_i,
   input  logic          id_ready_i,
   output logic          if_valid_o,
   output logic [31:0]   if_pc_o,
   output logic [31:0]   if_pc_plus4_o,
   output logic [31:0]   if_instr_o,
   output logic          if_misaligned_o,
   output logic          if_fault_o
);

   localparam if_id_t ENTRY_RST = '{pc: 32'h0, pc_plus4: 32'h4, instr: NOP_INSTR,
                                    misaligned: 1'b0, fault: 1'b0};

   logic [31:0] pc_q, pc_d;
   if_id_t      ent_q, ent_d;
   logic        vld_q, vld_d;
   logic        load;
   logic        mis, flt;

   assign imem_addr_o = pc_q[AW-1:0];

   // Next-state: redirect flushes and retargets, otherwise load or hold.
   always_comb begin
      pc_d  = pc_q;
      ent_d = ent_q;
      vld_d = vld_q;
      load  = !vld_q || id_ready_i;
      mis   = |pc_q[1:0];
      flt   = (pc_q >> AW) != 32'd0;
      if (redirect_valid_i) begin
         pc_d  = redirect_pc_i;
         vld_d = 1'b0;
      end else if (load) begin
         ent_d.pc         = pc_q;
         ent_d.pc_plus4   = pc_q + 32'd4;
         ent_d.instr      = (mis || flt) ? NOP_INSTR : imem_data_i;
         ent_d.misaligned = mis;
         ent_d.fault      = flt;
         vld_d            = 1'b1;
         pc_d             = pc_q + 32'd4;
      end
   end

   // PC and IF/ID state, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q  <= RESET_PC;
         ent_q <= ENTRY_RST;
         vld_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
   end

   assign if_valid_o      = vld_q;
   assign if_pc_o         = ent_q.pc;
   assign if_pc_plus4_o   = ent_q.pc_plus4;
   assign if_instr_o      = ent_q.instr;
   assign if_misaligned_o = ent_q.misaligned;
   assign if_fault_o      = ent_q.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, randomized run against a
// behavioural model, and asynchronous reset corner cases.
module tb_fetch_stage;

   localparam int          DEPTH = 8192;
   localparam int          AW    = 13;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic          redir;
   logic [31:0]   redir_pc;
   logic          ready;
   logic          vld;
   logic [31:0]   pc, pc4, instr;
   logic          mis, flt;

   logic [31:0] mem [0:DEPTH/4-1];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_vld;
   logic [31:0] m_epc, m_einstr;
   logic        m_mis, m_flt;

   fetch_stage dut (
      .clk_i(clk), .rst_i(rst),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
      .id_ready_i(ready),
      .if_valid_o(vld), .if_pc_o(pc), .if_pc_plus4_o(pc4), .if_instr_o(instr),
      .if_misaligned_o(mis), .if_fault_o(flt)
   );

   assign imem_data = mem[imem_addr[AW-1:2]];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_vld = 1'b0; m_epc = 32'h0; m_einstr = NOP;
      m_mis = 1'b0; m_flt = 1'b0;
   endtask

   // Behavioural rule: redirect beats everything; otherwise take a new entry
   // whenever decode is free or taking it.
   task automatic model_step(input logic r, input logic [31:0] rpc, input logic rdy);
      if (r) begin
         m_pc = rpc; m_vld = 1'b0;
      end else if (!m_vld || rdy) begin
         m_epc    = m_pc;
         m_mis    = (m_pc % 4) != 0;
         m_flt    = m_pc >= DEPTH;
         m_einstr = (m_mis || m_flt) ? NOP : mem[m_pc / 4];
         m_vld    = 1'b1;
         m_pc     = m_pc + 4;
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, {31'b0, vld}, {31'b0, m_vld});
      chk({tag, ".addr"}, {19'b0, imem_addr}, m_pc % DEPTH);
      chk({tag, ".pc"}, pc, m_epc);
      chk({tag, ".pc4"}, pc4, m_epc + 32'd4);
      chk({tag, ".instr"}, instr, m_einstr);
      chk({tag, ".mis"}, {31'b0, mis}, {31'b0, m_mis});
      chk({tag, ".flt"}, {31'b0, flt}, {31'b0, m_flt});
   endtask

   task automatic step(input logic r, input logic [31:0] rpc, input logic rdy);
      redir = r; redir_pc = rpc; ready = rdy;
      model_step(r, rpc, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".valid"}, {31'b0, vld}, 32'd0);
      chk({tag, ".pc"}, pc, 32'h0);
      chk({tag, ".pc4"}, pc4, 32'h4);
      chk({tag, ".instr"}, instr, NOP);
      chk({tag, ".flags"}, {30'b0, mis, flt}, 32'd0);
      chk({tag, ".addr"}, {19'b0, imem_addr}, 32'd0);
   endtask

   typedef struct {
      logic        r;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_mis;
      logic        e_flt;
   } vec_t;

   vec_t vecs [18];

   initial begin
      for (int i = 0; i < DEPTH / 4; i++) mem[i] = $urandom;
      mem[0]  = 32'h0050_0093;
      mem[1]  = 32'h00A0_0113;
      mem[2]  = 32'h00F0_0193;
      mem[3]  = 32'h0140_0213;
      mem[16] = 32'h0080_006F;

      //           r  rpc           rdy vld pc            instr          mis  flt
      vecs[0]  = '{0, 32'h0,        1,  1,  32'h0,        32'h0050_0093, 0, 0};
      vecs[1]  = '{0, 32'h0,        1,  1,  32'h4,        32'h00A0_0113, 0, 0};
      vecs[2]  = '{0, 32'h0,        1,  1,  32'h8,        32'h00F0_0193, 0, 0};
      vecs[3]  = '{0, 32'h0,        0,  1,  32'h8,        32'h00F0_0193, 0, 0};
      vecs[4]  = '{0, 32'h0,        0,  1,  32'h8,        32'h00F0_0193, 0, 0};
      vecs[5]  = '{0, 32'h0,        0,  1,  32'h8,        32'h00F0_0193, 0, 0};
      vecs[6]  = '{0, 32'h0,        1,  1,  32'hC,        32'h0140_0213, 0, 0};
      vecs[7]  = '{0, 32'h0,        0,  1,  32'hC,        32'h0140_0213, 0, 0};
      vecs[8]  = '{1, 32'h40,       0,  0,  32'h0,        32'h0,         0, 0};
      vecs[9]  = '{0, 32'h0,        0,  1,  32'h40,       32'h0080_006F, 0, 0};
      vecs[10] = '{1, 32'h42,       1,  0,  32'h0,        32'h0,         0, 0};
      vecs[11] = '{0, 32'h0,        1,  1,  32'h42,       NOP,           1, 0};
      vecs[12] = '{0, 32'h0,        1,  1,  32'h46,       NOP,           1, 0};
      vecs[13] = '{1, 32'h2000,     1,  0,  32'h0,        32'h0,         0, 0};
      vecs[14] = '{0, 32'h0,        1,  1,  32'h2000,     NOP,           0, 1};
      vecs[15] = '{1, 32'hFFFF_FFFC,1,  0,  32'h0,        32'h0,         0, 0};
      vecs[16] = '{0, 32'h0,        1,  1,  32'hFFFF_FFFC,NOP,           0, 1};
      vecs[17] = '{0, 32'h0,        1,  1,  32'h0,        32'h0050_0093, 0, 0};

      rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; ready = 1'b1;
      model_reset();
      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].rpc, vecs[i].rdy);
         chk($sformatf("vec%0d.valid", i), {31'b0, vld}, {31'b0, vecs[i].e_vld});
         if (vecs[i].e_vld) begin
            chk($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d.pc4", i), pc4, vecs[i].e_pc + 32'd4);
            chk($sformatf("vec%0d.instr", i), instr, vecs[i].e_instr);
            chk($sformatf("vec%0d.mis", i), {31'b0, mis}, {31'b0, vecs[i].e_mis});
            chk($sformatf("vec%0d.flt", i), {31'b0, flt}, {31'b0, vecs[i].e_flt});
         end
         if (i == 13) chk("oor.addr", {19'b0, imem_addr}, 32'h0);
         if (i == 16) chk("wrap.pc4", pc4, 32'h0);
      end

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic        r;
         logic [31:0] t;
         r = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: t = $urandom_range(0, DEPTH / 4 - 1) * 4;
            1: t = $urandom_range(0, DEPTH - 1);
            2: t = $urandom;
            default: t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         endcase
         step(r, t, ($urandom_range(0, 3) != 0));
         chk_model($sformatf("rnd%0d", n));
      end

      // Asynchronous reset while stalled, between clock edges
      step(0, 32'h0, 1);
      step(0, 32'h0, 0);
      #2 rst = 1'b1;
      #1 chk_reset_vals("areset_stall");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(0, 32'h0, 1);
      chk_model("post_areset");

      // Asynchronous reset while a redirect is being requested
      redir = 1'b1; redir_pc = 32'h80; ready = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset_vals("areset_redir");
      @(negedge clk);
      redir = 1'b0;
      rst = 1'b0;
      model_reset();
      step(0, 32'h0, 1);
      chk_model("post_areset2");
      step(0, 32'h0, 1);
      chk_model("post_areset3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I core. Owns the program counter, drives the word address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register. It presents that register to decode through a valid/ready handshake and accepts PC redirects from execute. The instruction memory is instantiated next to this block at core top level, not inside it.

## Interface
Parameters:
- IMEM_DEPTH, 8192: byte depth of instruction memory; AW = $clog2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk_i  in  1  core clock, all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- imem_addr_o  out  AW  byte address to instruction memory (pc_q[AW-1:0]).
- imem_data_i  in  32  instruction word, combinationally valid in the same cycle as imem_addr_o.
- redirect_valid_i  in  1  execute requests a PC change (taken branch/jump).
- redirect_pc_i  in  32  target PC for redirect.
- id_ready_i  in  1  decode can accept the IF/ID entry this cycle.
- if_valid_o  out  1  IF/ID entry valid.
- if_pc_o  out  32  PC of the held instruction.
- if_pc_plus4_o  out  32  if_pc_o + 4, wrapping mod 2^32.
- if_instr_o  out  32  held instruction, or NOP 32'h0000_0013 when faulted.
- if_misaligned_o  out  1  held PC had bits [1:0] != 0.
- if_fault_o  out  1  held PC had bits [31:AW] != 0 (outside imem).

## Operation
- imem_addr_o = pc_q[AW-1:0], purely combinational. No other memory control is needed.
- load = !if_valid_o || id_ready_i. IF/ID accepts a new entry only when load is 1.
- Priority each cycle:
  - 1. rst_i.
  - 2. redirect_valid_i: pc_q <= redirect_pc_i and if_valid_o <= 0. This flushes the held entry and discards the current fetch, even when id_ready_i = 0.
  - 3. load: IF/ID <= entry built from pc_q, and pc_q <= pc_q + 4.
  - 4. Otherwise hold: pc_q and all IF/ID outputs stay bit-stable.
- Entry construction:
  - misaligned = |pc_q[1:0].
  - fault = |pc_q[31:AW].
  - instr = (misaligned || fault) ? 32'h0000_0013 : imem_data_i.
  - The flags travel with the entry. Fetch continues sequentially after a flagged entry; trapping belongs to later stages.
- A misaligned redirect target is loaded unmodified. Increments keep the low bits, so every later entry also carries if_misaligned_o until the next redirect.
- pc_q + 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000. The entry fetched at the wrapped PC is flagged if_fault_o only if its upper bits are nonzero.

## Timing
- Reset values:
  - pc_q = RESET_PC.
  - if_valid_o = 0, if_pc_o = 0, if_pc_plus4_o = 4, if_instr_o = 32'h0000_0013.
  - if_misaligned_o = 0, if_fault_o = 0.
- After reset deassertion, the first edge loads the entry for RESET_PC; if_valid_o = 1 from cycle 1.
- Throughput is one instruction per cycle while id_ready_i = 1.
- Fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty:
  - The edge with redirect_valid_i = 1 clears valid.
  - The next edge presents the target instruction, so there is exactly 1 bubble.
- Handshake: while if_valid_o = 1 and id_ready_i = 0, the outputs must not change unless a redirect occurs.
- Asynchronous reset asserted mid-stall or mid-redirect forces all reset values immediately, independent of clk_i.

## Structure
- The shared package rv32i_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - The packed struct if_id_t {pc, pc_plus4, instr, misaligned, fault}, reused by decode.
- The IF/ID register is one if_id_t plus a separate valid bit.
- No sub-module: the PC register and IF/ID register are small enough to stay in one block.

## Test plan
- Reset with RESET_PC = 0 and imem words 0x00500093, 0x00A00113 at 0x0 and 0x4, id_ready_i = 1 -> if_pc_o is 0x0 then 0x4, if_instr_o is 0x00500093 then 0x00A00113, if_valid_o = 1 from cycle 1.
- Stall: hold id_ready_i = 0 for 3 cycles while an entry is valid at PC 0x8 -> if_pc_o = 0x8 and if_instr_o unchanged for all 3 cycles; pc_q advances only after ready returns.
- Redirect during stall: redirect_pc_i = 0x40 with id_ready_i = 0 -> next cycle if_valid_o = 0; cycle after shows if_pc_o = 0x40 with imem[0x40].
- Misaligned redirect to 0x42 -> entry has if_misaligned_o = 1 and if_instr_o = 0x00000013; next entry is at PC 0x46, still flagged.
- Out-of-range redirect to 0x0000_2000 with IMEM_DEPTH = 8192 -> if_fault_o = 1, if_instr_o = NOP, imem_addr_o = 0x000.
- Wrap: redirect to 0xFFFF_FFFC -> entry flagged fault with if_pc_plus4_o = 0x0; next entry at PC 0x0 is unflagged and valid.
